// File: rtl/core_mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> (MEM) -> WB, halting in TRAP.
// Owns PC, instruction register, write-back data and the retired-instruction counter.
module core_mc_sequencer #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // program memory
  output logic                  prog_req_o,
  output logic [ADDR_WIDTH-1:0] prog_addr_o,
  input  logic                  prog_ready_i,
  input  logic [DATA_WIDTH-1:0] prog_rdata_i,
  // data memory
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_ready_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  // decode / execute
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic                  is_branch_i,
  input  logic                  illegal_i,
  input  logic                  reg_we_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] exec_result_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  // status
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  reg_we_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  retire_o,
  output logic [31:0]           instret_o,
  output logic                  trap_o
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] next_pc_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [DATA_WIDTH-1:0] reg_wdata_reg;
  logic [DATA_WIDTH-1:0] store_data_reg;
  logic [31:0]           instret_reg;
  logic                  store_reg;
  logic                  reg_we_reg;
  logic                  misaligned;
  logic                  is_mem;

  assign misaligned = is_branch_i && (branch_target_i[1:0] != 2'b00);
  assign is_mem     = is_load_i || is_store_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: if (prog_ready_i) state_next = ST_EXEC;
      ST_EXEC: begin
        if (illegal_i || misaligned) state_next = ST_TRAP;
        else if (is_mem)             state_next = ST_MEM;
        else                         state_next = ST_WB;
      end
      ST_MEM:  if (data_ready_i) state_next = ST_WB;
      ST_WB:   state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      next_pc_reg    <= RESET_PC;
      mem_addr_reg   <= '0;
      instr_reg      <= '0;
      reg_wdata_reg  <= '0;
      store_data_reg <= '0;
      instret_reg    <= '0;
      store_reg      <= 1'b0;
      reg_we_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (prog_ready_i) instr_reg <= prog_rdata_i;
        end
        ST_EXEC: begin
          // A trapping instruction leaves all architectural state untouched.
          if (!illegal_i && !misaligned) begin
            next_pc_reg <= is_branch_i ? branch_target_i : pc_reg + ADDR_WIDTH'(4);
            reg_we_reg  <= reg_we_i;
            if (is_mem) begin
              mem_addr_reg   <= mem_addr_i;
              store_data_reg <= store_data_i;
              store_reg      <= is_store_i;
            end else begin
              reg_wdata_reg <= exec_result_i;
            end
          end
        end
        ST_MEM: begin
          if (data_ready_i) begin
            if (store_reg) reg_we_reg    <= 1'b0;
            else           reg_wdata_reg <= data_rdata_i;
          end
        end
        ST_WB: begin
          pc_reg      <= next_pc_reg;
          instret_reg <= instret_reg + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Strobes come from the state register only; rst_n masks the fetch request during reset.
  assign prog_req_o   = rst_n && (state_reg == ST_FETCH);
  assign prog_addr_o  = pc_reg;
  assign data_req_o   = (state_reg == ST_MEM);
  assign data_we_o    = (state_reg == ST_MEM) && store_reg;
  assign data_addr_o  = mem_addr_reg;
  assign data_wdata_o = store_data_reg;
  assign instr_o      = instr_reg;
  assign pc_o         = pc_reg;
  assign reg_we_o     = (state_reg == ST_WB) && reg_we_reg;
  assign reg_wdata_o  = reg_wdata_reg;
  assign retire_o     = (state_reg == ST_WB);
  assign instret_o    = instret_reg;
  assign trap_o       = (state_reg == ST_TRAP);

endmodule

// File: tb/tb_core_mc_sequencer.sv
// Directed bench for core_mc_sequencer: table of single instructions acting as both
// memories, plus a reset-during-MEM-wait sequence.
module tb_core_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_req_o;
  logic [9:0]  prog_addr_o;
  logic        prog_ready_i = 1'b0;
  logic [31:0] prog_rdata_i = '0;
  logic        data_req_o, data_we_o;
  logic [9:0]  data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_ready_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        is_load_i = 1'b0, is_store_i = 1'b0, is_branch_i = 1'b0;
  logic        illegal_i = 1'b0, reg_we_i = 1'b0;
  logic [9:0]  branch_target_i = '0, mem_addr_i = '0;
  logic [31:0] exec_result_i = '0, store_data_i = '0;
  logic [31:0] instr_o, reg_wdata_o, instret_o;
  logic [9:0]  pc_o;
  logic        reg_we_o, retire_o, trap_o;

  int checks = 0;
  int errors = 0;
  logic [9:0]  exp_pc;
  logic [31:0] exp_instret;

  always #5 clk = ~clk;

  core_mc_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_req_o(prog_req_o), .prog_addr_o(prog_addr_o),
    .prog_ready_i(prog_ready_i), .prog_rdata_i(prog_rdata_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_ready_i(data_ready_i), .data_rdata_i(data_rdata_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_branch_i(is_branch_i),
    .illegal_i(illegal_i), .reg_we_i(reg_we_i), .branch_target_i(branch_target_i),
    .mem_addr_i(mem_addr_i), .exec_result_i(exec_result_i), .store_data_i(store_data_i),
    .instr_o(instr_o), .pc_o(pc_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .retire_o(retire_o), .instret_o(instret_o), .trap_o(trap_o)
  );

  typedef struct {
    logic        ld, st, br, ill, we;
    logic [9:0]  target, maddr;
    logic [31:0] result, sdata, instr, rdata;
    int          fwait, dwait, exp_cyc;
    logic        exp_trap, exp_mem, exp_we;
    logic [31:0] exp_wdata;
    logic [9:0]  exp_npc;
    logic [31:0] exp_iret;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    prog_ready_i = 0; data_ready_i = 0;
    is_load_i = 0; is_store_i = 0; is_branch_i = 0; illegal_i = 0; reg_we_i = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_strobes", {prog_req_o, data_req_o, reg_we_o, retire_o, trap_o}, 5'b0);
    check("rst_pc", pc_o, 10'h000);
    check("rst_instr", instr_o, 32'h0);
    check("rst_instret", instret_o, 32'h0);
    check("rst_wdata", reg_wdata_o, 32'h0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_fetch", {prog_req_o, prog_addr_o}, {1'b1, 10'h000});
    exp_pc = 10'h000;
    exp_instret = 32'h0;
    $display("reset: prog_req=%0b prog_addr=%0h", prog_req_o, prog_addr_o);
  endtask

  // Entered at a negedge with the DUT in FETCH; acts as both memories.
  task automatic run_row(input int idx, input vec_t v);
    logic got_ret = 0, got_trap = 0, saw_dreq = 0, excl_ok = 1, addr_ok = 1, hold_ok = 1;
    logic we = 0, dwe = 0;
    logic [31:0] wd = '0, dwd = '0;
    logic [9:0] first_addr = '0;
    int ret_cyc = 0, fw = 0, dw = 0, mem_cyc = 0;
    check($sformatf("r%0d_fetch_addr", idx), {prog_req_o, prog_addr_o}, {1'b1, exp_pc});
    is_load_i = v.ld; is_store_i = v.st; is_branch_i = v.br; illegal_i = v.ill;
    reg_we_i = v.we; branch_target_i = v.target; mem_addr_i = v.maddr;
    exec_result_i = v.result; store_data_i = v.sdata;
    prog_rdata_i = v.instr; data_rdata_i = v.rdata;
    for (int cyc = 1; cyc <= 30 && !(got_ret || got_trap); cyc++) begin
      if (int'(prog_req_o) + int'(data_req_o) + int'(reg_we_o) > 1) excl_ok = 0;
      if (prog_req_o) begin
        prog_ready_i = (fw == v.fwait); fw++;
        data_ready_i = 1;
      end else if (data_req_o) begin
        if (!saw_dreq) begin
          first_addr = data_addr_o; dwe = data_we_o; dwd = data_wdata_o;
        end else if (data_addr_o !== first_addr || data_we_o !== dwe || data_wdata_o !== dwd) begin
          addr_ok = 0;
        end
        saw_dreq = 1; mem_cyc++;
        data_ready_i = (dw == v.dwait); dw++;
        prog_ready_i = 1;
      end else if (retire_o) begin
        got_ret = 1; ret_cyc = cyc; we = reg_we_o; wd = reg_wdata_o;
        prog_ready_i = 0; data_ready_i = 0;
      end else if (trap_o) begin
        got_trap = 1; ret_cyc = cyc;
        prog_ready_i = 0; data_ready_i = 0;
      end else begin
        prog_ready_i = 1; data_ready_i = 1;
      end
      if (!(got_ret || got_trap)) @(negedge clk);
    end
    check($sformatf("r%0d_completed", idx), got_ret | got_trap, 1'b1);
    check($sformatf("r%0d_trap", idx), got_trap, v.exp_trap);
    check($sformatf("r%0d_cycles", idx), ret_cyc, v.exp_cyc);
    check($sformatf("r%0d_data_req", idx), saw_dreq, v.exp_mem);
    check($sformatf("r%0d_exclusive", idx), excl_ok, 1'b1);
    if (saw_dreq) begin
      check($sformatf("r%0d_data_addr", idx), first_addr, v.maddr);
      check($sformatf("r%0d_data_stable", idx), addr_ok, 1'b1);
      check($sformatf("r%0d_mem_cycles", idx), mem_cyc, v.dwait + 1);
      check($sformatf("r%0d_data_we", idx), dwe, v.st);
      if (v.st) check($sformatf("r%0d_data_wdata", idx), dwd, v.sdata);
    end
    if (got_ret) begin
      check($sformatf("r%0d_reg_we", idx), we, v.exp_we);
      if (v.exp_we) check($sformatf("r%0d_reg_wdata", idx), wd, v.exp_wdata);
      @(negedge clk);
      check($sformatf("r%0d_next_pc", idx), {prog_req_o, prog_addr_o, pc_o}, {1'b1, v.exp_npc, v.exp_npc});
      check($sformatf("r%0d_instret", idx), instret_o, v.exp_iret);
      check($sformatf("r%0d_instr", idx), instr_o, v.instr);
      exp_pc = v.exp_npc;
      exp_instret = v.exp_iret;
    end else if (got_trap) begin
      for (int k = 0; k < 4; k++) begin
        prog_ready_i = 1; data_ready_i = 1;
        @(negedge clk);
        if (prog_req_o || data_req_o || reg_we_o || retire_o || !trap_o ||
            pc_o !== v.exp_npc || instret_o !== v.exp_iret || instr_o !== v.instr) hold_ok = 0;
      end
      check($sformatf("r%0d_trap_hold", idx), hold_ok, 1'b1);
    end
    $display("row %0d: retire=%0b trap=%0b cycles=%0d reg_we=%0b wdata=%0h pc=%0h instret=%0d",
             idx, got_ret, got_trap, ret_cyc, we, wd, pc_o, instret_o);
    if (got_trap) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ld st br ill we | target maddr | result sdata instr rdata | fwait dwait cyc | trap mem we | wdata | npc | instret
    vecs[0]  = '{0,0,0,0,1, 10'h000, 10'h000, 32'h12345678, 32'h0, 32'h00000013, 32'h0, 0,0,3, 0,0,1, 32'h12345678, 10'h004, 32'd1};
    vecs[1]  = '{1,0,0,0,1, 10'h000, 10'h040, 32'h0, 32'h0, 32'h04002003, 32'hDEADBEEF, 0,2,6, 0,1,1, 32'hDEADBEEF, 10'h008, 32'd2};
    vecs[2]  = '{0,1,0,0,1, 10'h000, 10'h080, 32'h0, 32'hA5A5A5A5, 32'h08A02023, 32'h0, 0,0,4, 0,1,0, 32'h0, 10'h00C, 32'd3};
    vecs[3]  = '{0,0,0,0,0, 10'h000, 10'h000, 32'h1, 32'h0, 32'h00100093, 32'h0, 1,0,4, 0,0,0, 32'h0, 10'h010, 32'd4};
    vecs[4]  = '{0,0,1,0,0, 10'h100, 10'h000, 32'h0, 32'h0, 32'h0F000063, 32'h0, 0,0,3, 0,0,0, 32'h0, 10'h100, 32'd5};
    vecs[5]  = '{0,0,1,0,0, 10'h3FC, 10'h000, 32'h0, 32'h0, 32'h2FC00063, 32'h0, 0,0,3, 0,0,0, 32'h0, 10'h3FC, 32'd6};
    vecs[6]  = '{0,0,0,0,1, 10'h000, 10'h000, 32'hCAFEF00D, 32'h0, 32'h00208033, 32'h0, 0,0,3, 0,0,1, 32'hCAFEF00D, 10'h000, 32'd7};
    vecs[7]  = '{1,0,0,0,1, 10'h000, 10'h3F0, 32'h55, 32'h0, 32'h3F002083, 32'h0BADF00D, 2,0,6, 0,1,1, 32'h0BADF00D, 10'h004, 32'd8};
    vecs[8]  = '{0,0,1,0,0, 10'h102, 10'h000, 32'h0, 32'h0, 32'h10200063, 32'h0, 0,0,3, 1,0,0, 32'h0, 10'h004, 32'd8};
    vecs[9]  = '{0,0,0,0,1, 10'h000, 10'h000, 32'h0000BEEF, 32'h0, 32'h00000113, 32'h0, 0,0,3, 0,0,1, 32'h0000BEEF, 10'h004, 32'd1};
    vecs[10] = '{1,0,0,1,1, 10'h000, 10'h040, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 0,0,3, 1,0,0, 32'h0, 10'h004, 32'd1};

    exp_pc = 10'h000;
    exp_instret = 32'h0;
    do_reset();
    for (int i = 0; i < 11; i++) run_row(i, vecs[i]);

    // Reset pulsed during a stalled load must drop data_req at once and restart at RESET_PC.
    is_load_i = 1; reg_we_i = 1; mem_addr_i = 10'h040;
    prog_rdata_i = 32'h04002003; prog_ready_i = 1; data_ready_i = 0;
    @(negedge clk);
    prog_ready_i = 0;
    @(negedge clk);
    check("mem_wait_req_1", data_req_o, 1'b1);
    @(negedge clk);
    check("mem_wait_req_2", {data_req_o, reg_we_o, retire_o}, 3'b100);
    $display("mem wait: data_req=%0b data_addr=%0h", data_req_o, data_addr_o);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mc_sequencer.md
CORE_MC_SEQUENCER -- requirements
Module: core_mc_sequencer

Interface
REQ-001 Parameters, one per line:
- ADDR_WIDTH, 10, byte-address width of the program and data memories.
- DATA_WIDTH, 32, instruction and data word width.
- RESET_PC, 0, PC value loaded at reset.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 Program memory ports:
- prog_req_o  out  1  fetch request.
- prog_addr_o  out  ADDR_WIDTH  fetch address (the PC).
- prog_ready_i  in  1  fetch complete; prog_rdata_i is valid in the same cycle.
- prog_rdata_i  in  DATA_WIDTH  instruction word.
REQ-004 Data memory ports:
- data_req_o  out  1  access request.
- data_we_o  out  1  1 = store, 0 = load.
- data_addr_o  out  ADDR_WIDTH  access address.
- data_wdata_o  out  DATA_WIDTH  store data.
- data_ready_i  in  1  access complete.
- data_rdata_i  in  DATA_WIDTH  load data, valid when data_ready_i=1.
REQ-005 Decode/execute ports (driven combinationally by external logic from instr_o):
- is_load_i, is_store_i, is_branch_i, illegal_i, reg_we_i  in  1 each  instruction class and register-write flags.
- branch_target_i  in  ADDR_WIDTH  branch target address.
- mem_addr_i  in  ADDR_WIDTH  load/store address.
- exec_result_i, store_data_i  in  DATA_WIDTH  ALU result and store data.
REQ-006 Status outputs:
- instr_o  out  DATA_WIDTH  latched instruction register.
- pc_o  out  ADDR_WIDTH  current PC.
- reg_we_o  out  1  register-file write strobe.
- reg_wdata_o  out  DATA_WIDTH  register-file write data.
- retire_o  out  1  one-cycle pulse per retired instruction.
- instret_o  out  32  retired-instruction count.
- trap_o  out  1  core halted.

Function
REQ-007 FSM states: FETCH, EXEC, MEM, WB, TRAP. The encoding is free.
REQ-008 FETCH:
- prog_req_o=1 and prog_addr_o=pc.
- On prog_ready_i=1: latch prog_rdata_i into instr_o and go to EXEC.
- Otherwise stay in FETCH with the address held stable.
REQ-009 EXEC lasts exactly one cycle:
- illegal_i=1 -> TRAP; illegal_i has priority over every other flag.
- else is_load_i or is_store_i -> MEM; latch mem_addr_i, store_data_i, is_store_i and reg_we_i.
- else -> WB; latch exec_result_i into reg_wdata_o and latch reg_we_i.
- If is_branch_i=1 and branch_target_i[1:0]!=0 -> TRAP.
- Otherwise latch the next PC: branch_target_i if is_branch_i=1, else pc+4 modulo 2^ADDR_WIDTH.
REQ-010 MEM:
- data_req_o=1; data_addr_o, data_we_o and data_wdata_o stay constant until data_ready_i=1.
- On data_ready_i=1, load: latch data_rdata_i into reg_wdata_o, then WB.
- On data_ready_i=1, store: force the latched reg_we to 0, then WB.
REQ-011 WB lasts exactly one cycle:
- reg_we_o equals the latched reg_we.
- retire_o=1.
- instret_o increments by 1, wrapping from 0xFFFFFFFF to 0.
- pc takes the next-PC value.
- Go to FETCH.
REQ-012 TRAP:
- trap_o=1.
- All request and write strobes stay 0.
- pc, instr_o and instret_o stay frozen.
- Only reset leaves TRAP.
REQ-013 Strobe exclusivity:
- prog_req_o=1 only in FETCH; data_req_o=1 only in MEM; reg_we_o and retire_o only in WB.
- Never more than one of prog_req_o, data_req_o and reg_we_o is 1 in the same cycle.
REQ-014 Ready inputs arriving in the wrong state are ignored:
- prog_ready_i outside FETCH.
- data_ready_i outside MEM.
REQ-015 Latency with zero wait states:
- Non-memory instruction: 3 cycles (FETCH, EXEC, WB).
- Load or store: 4 cycles.
- Each wait cycle adds exactly one cycle.
REQ-016 Request strobes are decoded from registered state only; there is no combinational path from any ready input to any request output.

Reset
REQ-017 While rst_n=0, asynchronously:
- state=FETCH, pc=RESET_PC.
- instr_o, reg_wdata_o and instret_o are 0.
- All strobes and trap_o are 0.
- prog_req_o is held at 0 during reset.
REQ-018 prog_req_o first asserts in the first clock cycle after rst_n deasserts.
REQ-019 A reset asserted in any state aborts any in-flight fetch or data access with no write and no retire.

Verification
REQ-020 Reset, then ALU instruction, reg_we_i=1, exec_result_i=0x12345678, zero wait -> reg_we_o=1 with reg_wdata_o=0x12345678 in cycle 3; pc 0->4; instret_o=1.
REQ-021 Load, mem_addr_i=0x040, data_rdata_i=0xDEADBEEF, data_ready_i delayed 2 cycles -> data_addr_o=0x040 held stable 3 cycles; reg_wdata_o=0xDEADBEEF; retire 6 cycles after the fetch request.
REQ-022 Store, store_data_i=0xA5A5A5A5 -> data_we_o=1, data_wdata_o=0xA5A5A5A5; reg_we_o stays 0 in WB; retire_o=1.
REQ-023 Branch:
- target 0x100 -> next prog_addr_o=0x100.
- target 0x102 -> trap_o=1, no further prog_req_o until reset.
- pc=0x3FC with no branch (ADDR_WIDTH=10) -> next fetch at 0x000.
REQ-024 illegal_i=1 together with is_load_i=1 -> TRAP; data_req_o never asserts; instret_o unchanged.
REQ-025 rst_n pulsed low during a MEM wait -> data_req_o drops immediately; no reg_we_o; fetch restarts at RESET_PC.
